fu_sched: RTL



---
 rtl/fu_sched.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/fu_sched.sv
`default_nettype none
// ============================================================================
// Module   : fu_sched
// Purpose  : Scheduler for a shared multi-cycle function unit. Arbitrates the
//            unit between the CPU pipeline (port 0, tagged writeback) and a
//            debug/self-test requester (port 1). It sequences start/busy,
//            captures the result and returns it to the owning port. It also
//            freezes the pipeline while port 0 waits and flags a hung unit
//            with a sticky timeout error.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            req0_i/a0_i/b0_i/tag0_i - port-0 request, operands, dest tag
//            stall0_o                - pipeline freeze (req0 & ~done0)
//            done0_o/res0_o/tag0_o   - port-0 completion, result (32b), tag
//            req1_i/a1_i/b1_i        - port-1 request and operands
//            ack1_o                  - port-1 grant pulse
//            done1_o/res1_o          - port-1 completion and result
//            fu_start_o/fu_a_o/fu_b_o/fu_busy_i/fu_y_i - function unit side
//            err_o                   - sticky timeout flag
//            busy_o                  - scheduler not idle
// Revision : 1.0 - initial release
// ============================================================================
module fu_sched #(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 24,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_i,
    input  logic [DATA_W-1:0] a0_i,
    input  logic [DATA_W-1:0] b0_i,
    input  logic [TAG_W-1:0]  tag0_i,
    output logic              stall0_o,
    output logic              done0_o,
    output logic [31:0]       res0_o,
    output logic [TAG_W-1:0]  tag0_o,
    input  logic              req1_i,
    input  logic [DATA_W-1:0] a1_i,
    input  logic [DATA_W-1:0] b1_i,
    output logic              ack1_o,
    output logic              done1_o,
    output logic [RES_W-1:0]  res1_o,
    output logic              fu_start_o,
    output logic [DATA_W-1:0] fu_a_o,
    output logic [DATA_W-1:0] fu_b_o,
    input  logic              fu_busy_i,
    input  logic [RES_W-1:0]  fu_y_i,
    output logic              err_o,
    output logic              busy_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_RUN       = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t             r_state_q,      w_state_d;
    logic               r_last_grant_q, w_last_grant_d;
    logic               r_owner_q,      w_owner_d;
    logic [DATA_W-1:0]  r_a_q,          w_a_d;
    logic [DATA_W-1:0]  r_b_q,          w_b_d;
    logic [TAG_W-1:0]   r_tag_q,        w_tag_d;
    logic [TAG_W-1:0]   r_tag0_q,       w_tag0_d;
    logic [CNT_W-1:0]   r_cnt_q,        w_cnt_d;
    logic               r_err_q,        w_err_d;
    logic               r_start_q,      w_start_d;
    logic               r_done0_q,      w_done0_d;
    logic               r_done1_q,      w_done1_d;
    logic [31:0]        r_res0_q,       w_res0_d;
    logic [RES_W-1:0]   r_res1_q,       w_res1_d;

    logic w_req_any;
    logic w_grant_port;
    logic w_finish;
    logic w_timeout;

    assign w_req_any = req0_i | req1_i;
    // With both ports requesting, the port that was not served last wins;
    // otherwise the single requester wins.
    assign w_grant_port = (req0_i & req1_i) ? ~r_last_grant_q : req1_i;

    always_comb begin
        w_state_d      = r_state_q;
        w_last_grant_d = r_last_grant_q;
        w_owner_d      = r_owner_q;
        w_a_d          = r_a_q;
        w_b_d          = r_b_q;
        w_tag_d        = r_tag_q;
        w_tag0_d       = r_tag0_q;
        w_cnt_d        = r_cnt_q;
        w_err_d        = r_err_q;
        w_res0_d       = r_res0_q;
        w_res1_d       = r_res1_q;
        w_start_d      = 1'b0;
        w_done0_d      = 1'b0;
        w_done1_d      = 1'b0;
        w_finish       = 1'b0;
        w_timeout      = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_state_d      = ST_ISSUE;
                    w_start_d      = 1'b1;
                    w_owner_d      = w_grant_port;
                    w_last_grant_d = w_grant_port;
                    w_a_d          = w_grant_port ? a1_i : a0_i;
                    w_b_d          = w_grant_port ? b1_i : b0_i;
                    w_tag_d        = w_grant_port ? '0 : tag0_i;
                end
            end
            ST_ISSUE: begin
                w_cnt_d   = '0;
                w_state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (fu_busy_i) begin
                    w_state_d = ST_RUN;
                end else if (r_cnt_q == C_CNT_LAST) begin
                    w_timeout = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!fu_busy_i) begin
                    w_finish = 1'b1;
                end else if (r_cnt_q == C_CNT_LAST) begin
                    w_timeout = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Always pass through IDLE so arbitration sees a clean cycle.
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Normal completion and timeout share the hand-back path; a timed
        // out operation returns zero to its owner.
        if (w_finish | w_timeout) begin
            w_state_d = ST_DONE;
            if (w_timeout) begin
                w_err_d = 1'b1;
            end
            if (r_owner_q) begin
                w_res1_d  = w_timeout ? '0 : fu_y_i;
                w_done1_d = 1'b1;
            end else begin
                w_res0_d  = w_timeout ? '0 : 32'(fu_y_i);
                w_tag0_d  = r_tag_q;
                w_done0_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_last_grant_q <= 1'b1;
            r_owner_q      <= 1'b0;
            r_a_q          <= '0;
            r_b_q          <= '0;
            r_tag_q        <= '0;
            r_tag0_q       <= '0;
            r_cnt_q        <= '0;
            r_err_q        <= 1'b0;
            r_start_q      <= 1'b0;
            r_done0_q      <= 1'b0;
            r_done1_q      <= 1'b0;
            r_res0_q       <= '0;
            r_res1_q       <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_last_grant_q <= w_last_grant_d;
            r_owner_q      <= w_owner_d;
            r_a_q          <= w_a_d;
            r_b_q          <= w_b_d;
            r_tag_q        <= w_tag_d;
            r_tag0_q       <= w_tag0_d;
            r_cnt_q        <= w_cnt_d;
            r_err_q        <= w_err_d;
            r_start_q      <= w_start_d;
            r_done0_q      <= w_done0_d;
            r_done1_q      <= w_done1_d;
            r_res0_q       <= w_res0_d;
            r_res1_q       <= w_res1_d;
        end
    end

    // The acceptance pulse coincides with the grant decision so a port-1
    // requester can drop its request right after the granting edge. It is
    // masked during reset because no grant is taken on that edge.
    assign ack1_o     = (r_state_q == ST_IDLE) & w_req_any & w_grant_port & ~rst;
    // Released in the completion cycle so the pipeline advances on that edge.
    assign stall0_o   = req0_i & ~r_done0_q;
    assign busy_o     = (r_state_q != ST_IDLE);
    assign done0_o    = r_done0_q;
    assign done1_o    = r_done1_q;
    assign res0_o     = r_res0_q;
    assign res1_o     = r_res1_q;
    assign tag0_o     = r_tag0_q;
    assign fu_start_o = r_start_q;
    assign fu_a_o     = r_a_q;
    assign fu_b_o     = r_b_q;
    assign err_o      = r_err_q;

endmodule
`default_nettype wire
